fpu_addsub_sched: RTL and testbench
===================================

FPU_ADDSUB_SCHED -- requirements
Module: fpu_addsub_sched

Interface
Parameters (name, default, meaning):
REQ-001 DEPTH, 4, maximum number of operations outstanding in the shared adder (tag-queue depth, power of 2, 2..16).

Ports (name, direction, width, meaning):
REQ-002 clk, in, 1, clock; all state updates on posedge.
REQ-003 rst, in, 1, synchronous active-high reset.
REQ-004 req_valid, in, 2, per-requester operation request.
REQ-005 req_ready, out, 2, per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-006 req_sub, in, 2, per-requester opcode: 0 = A+B, 1 = A-B.
REQ-007 req_a0, req_b0, req_a1, req_b1, in, 32 each, IEEE-754 single-precision operands for requesters 0 and 1.
REQ-008 rsp_valid, out, 2, one-cycle pulse marking a result for requester i; there is no backpressure.
REQ-009 rsp_data, out, 32, result word, valid when any rsp_valid bit is high.
REQ-010 fpu_din1, fpu_din2, out, 32 each, operands to the shared single-precision adder.
REQ-011 fpu_dval, out, 1, operand-valid strobe to the adder.
REQ-012 fpu_result, in, 32, adder result.
REQ-013 fpu_rdy, in, 1, adder result strobe; results return in issue order.
REQ-014 busy, out, 1, high while outstanding count is nonzero or fpu_dval is high.
REQ-015 err, out, 1, sticky protocol-error flag.

Function
REQ-016 The block SHALL share one adder between two requesters and SHALL implement subtraction by inverting bit 31 of B before issue; bits 30:0 pass unchanged.
REQ-017 Outstanding count (cnt, 0..DEPTH) SHALL increment on an accepted request, decrement on fpu_rdy with a non-empty queue, and stay unchanged when both occur in the same cycle.
REQ-018 req_ready SHALL be zero for both requesters when registered cnt == DEPTH; a pop in the same cycle does not bypass this (no credit forwarding).
REQ-019 When cnt < DEPTH, at most one req_ready bit SHALL be high: the requester holding priority if it is valid, otherwise the other requester if it is valid.
REQ-020 req_ready SHALL be combinational from req_valid, cnt and the priority pointer; it SHALL NOT depend on fpu_rdy.
REQ-021 Priority pointer: resets to requester 0, and after each grant moves to the requester that was not granted (round-robin); it is unchanged in cycles with no grant.
REQ-022 On acceptance in cycle N, fpu_din1/fpu_din2 SHALL carry the selected (A, B-possibly-negated) and fpu_dval SHALL be high in cycle N+1 for exactly one cycle; back-to-back acceptances produce back-to-back fpu_dval.
REQ-023 fpu_din1/fpu_din2 SHALL hold their last values when fpu_dval is low.
REQ-024 On acceptance, the granted requester ID SHALL be pushed to a DEPTH-entry FIFO tag queue with wrap-around pointers.
REQ-025 On fpu_rdy in cycle M with a non-empty queue, the head tag SHALL be popped, rsp_data SHALL equal fpu_result and rsp_valid[tag] SHALL pulse in cycle M+1; at most one rsp_valid bit is high per cycle.
REQ-026 On fpu_rdy with an empty queue, err SHALL be set and remain set until reset; the result is dropped and cnt stays 0.
REQ-027 rsp_data SHALL hold its value when no rsp_valid bit is high.
REQ-028 The block SHALL NOT inspect or modify operand contents beyond the sign inversion; NaN, Inf and denormal values pass through unchanged.
REQ-029 Simultaneous push and pop when the queue is at DEPTH-1 or 1 SHALL keep queue contents and order correct.

Reset
REQ-030 When rst is high at a clock edge: req_ready=0, fpu_dval=0, fpu_din1=fpu_din2=0, rsp_valid=0, rsp_data=0, cnt=0, queue pointers=0, priority pointer=0, busy=0, err=0.
REQ-031 Reset mid-operation SHALL discard all outstanding tags. The adder shares rst; any fpu_rdy after reset with an empty queue follows REQ-026.
REQ-032 req_ready SHALL be low during every cycle in which rst is high.

Verification
REQ-033 Req0 A=0x3F800000, B=0x40000000, sub=0 -> fpu_din2=0x40000000, fpu_dval high 1 cycle later; adder returns 0x40400000 -> rsp_valid=2'b01, rsp_data=0x40400000.
REQ-034 Req1 A=0x40400000, B=0x3F800000, sub=1 -> fpu_din2=0xBF800000; result 0x40000000 returns on rsp_valid=2'b10.
REQ-035 Both requesters valid continuously for 6 cycles, adder model latency 3 -> grants alternate 0,1,0,1,...; responses arrive in issue order with the correct tags.
REQ-036 Adder model stalled with DEPTH=4 and 5 requests -> 4 accepted, req_ready=0 while cnt=4; pop and push in the same cycle -> cnt unchanged, ordering preserved.
REQ-037 fpu_rdy pulsed with no outstanding operations -> err=1 and held; rst high -> err=0 and all outputs at their reset values.
REQ-038 Assert rst with 3 operations outstanding -> cnt=0, busy=0, no rsp_valid pulses for the flushed operations.

Source files
------------

// File: rtl/fpu_addsub_sched.sv
// Two-requester scheduler for one shared single-precision adder; subtract is done by flipping B's sign.
// Latency: operands reach the adder one cycle after acceptance; a response follows fpu_rdy by one cycle.
// Backpressure: requests are held off while DEPTH ops are outstanding; responses cannot be stalled.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready/req_sub per-requester handshake and opcode (0 = A+B, 1 = A-B)
//   req_a0/req_b0/req_a1/req_b1 operands for requester 0 and requester 1
//   rsp_valid/rsp_data          one-cycle result pulse, tagged by requester
//   fpu_din1/fpu_din2/fpu_dval  operand issue to the shared adder
//   fpu_result/fpu_rdy          in-order result return from the adder
//   busy, err                   activity indicator, sticky unexpected-result flag
module fpu_addsub_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_sub,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        busy,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] cnt;
  logic          prio;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          tag_q [DEPTH];

  logic          full;
  logic          empty;
  logic [1:0]    gnt;
  logic          push;
  logic          pop;
  logic          grant_id;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  logic          sel_sub;
  logic          head_tag;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Grant uses only the registered count: a pop in this cycle frees no slot
  // until the next one, which keeps fpu_rdy out of the ready path.
  always_comb begin
    req_ready = 2'b00;
    if (!rst && !full) begin
      if (req_valid[prio])
        req_ready[prio] = 1'b1;
      else if (req_valid[~prio])
        req_ready[~prio] = 1'b1;
    end
  end

  assign gnt      = req_valid & req_ready;
  assign push     = |gnt;
  assign grant_id = gnt[1];
  assign pop      = fpu_rdy && !empty;
  assign head_tag = tag_q[rd_ptr];

  assign sel_a   = grant_id ? req_a1 : req_a0;
  assign sel_b   = grant_id ? req_b1 : req_b0;
  assign sel_sub = req_sub[grant_id];

  assign busy = (cnt != '0) || fpu_dval;

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push)
      tag_q[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      prio      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fpu_dval  <= 1'b0;
      fpu_din1  <= '0;
      fpu_din2  <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      err       <= 1'b0;
    end else begin
      fpu_dval <= push;
      if (push) begin
        fpu_din1 <= sel_a;
        fpu_din2 <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
        wr_ptr   <= wr_ptr + 1'b1;
        prio     <= ~grant_id;
      end

      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      rsp_valid <= {pop & head_tag, pop & ~head_tag};
      if (pop)
        rsp_data <= fpu_result;

      // A result with nothing outstanding is dropped and flagged until reset.
      if (fpu_rdy && empty)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Directed bench for fpu_addsub_sched (DEPTH=4); the adder is played by hand from the stimulus.
// Inputs change 2 time units after each rising edge; comparisons are made 1 unit later.
// Stalls and result returns are scripted per cycle, so no waits depend on the DUT.
module tb_fpu_addsub_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_sub;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] fpu_din1, fpu_din2;
  logic        fpu_dval;
  logic [31:0] fpu_result;
  logic        fpu_rdy;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  fpu_addsub_sched #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_dval   (fpu_dval),
    .fpu_result (fpu_result),
    .fpu_rdy    (fpu_rdy),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_tag [4];

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_sub = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    fpu_rdy = 1'b0; fpu_result = '0;

    // Reset state, with both requesters already asking.
    tick(); tick();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dval", 32'(fpu_dval), 32'd0);
    chk("rst_din1", fpu_din1, 32'd0);
    chk("rst_din2", fpu_din2, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0; req_valid = 2'b00;
    tick();

    // Requester 0: 1.0 + 2.0.
    req_valid = 2'b01; req_a0 = 32'h3F800000; req_b0 = 32'h40000000; req_sub = 2'b00;
    #1 chk("t1_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_dval", 32'(fpu_dval), 32'd1);
    chk("t1_din1", fpu_din1, 32'h3F800000);
    chk("t1_din2", fpu_din2, 32'h40000000);
    tick();
    chk("t1_dval_pulse", 32'(fpu_dval), 32'd0);
    chk("t1_din2_hold", fpu_din2, 32'h40000000);
    chk("t1_busy", 32'(busy), 32'd1);
    fpu_rdy = 1'b1; fpu_result = 32'h40400000;
    tick();
    fpu_rdy = 1'b0;
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data", rsp_data, 32'h40400000);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("t1_rsp_hold", rsp_data, 32'h40400000);

    // Requester 1: 3.0 - 1.0, sign of B flipped.
    req_valid = 2'b10; req_a1 = 32'h40400000; req_b1 = 32'h3F800000; req_sub = 2'b10;
    #1 chk("t2_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    chk("t2_dval", 32'(fpu_dval), 32'd1);
    chk("t2_din1", fpu_din1, 32'h40400000);
    chk("t2_din2", fpu_din2, 32'hBF800000);
    fpu_rdy = 1'b1; fpu_result = 32'h40000000;
    tick();
    fpu_rdy = 1'b0;
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("t2_rsp_data", rsp_data, 32'h40000000);

    // Both requesters streaming for 6 cycles; results return 3 cycles after acceptance.
    req_a0 = 32'h11111111; req_b0 = 32'h33333333;
    req_a1 = 32'h22222222; req_b1 = 32'h44444444; req_sub = 2'b00;
    for (int k = 0; k <= 10; k++) begin
      req_valid  = (k < 6) ? 2'b11 : 2'b00;
      fpu_rdy    = (k >= 3 && k < 9);
      fpu_result = 32'hC0DE0000 + 32'(k - 3);
      #1;
      if (k < 6)
        chk("t3_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 1 && k <= 6) begin
        chk("t3_dval", 32'(fpu_dval), 32'd1);
        chk("t3_din1", fpu_din1, ((k - 1) % 2 == 0) ? 32'h11111111 : 32'h22222222);
      end
      if (k >= 4 && k <= 9) begin
        chk("t3_rsp_tag", 32'(rsp_valid), ((k - 4) % 2 == 0) ? 32'd1 : 32'd2);
        chk("t3_rsp_data", rsp_data, 32'hC0DE0000 + 32'(k - 4));
      end
      tick();
    end
    fpu_rdy = 1'b0;
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_rsp_end", 32'(rsp_valid), 32'd0);

    // Adder stalled: five requests, only four accepted.
    req_valid = 2'b01; req_b0 = '0; req_sub = 2'b00;
    for (int k = 0; k <= 4; k++) begin
      req_a0 = 32'h100 + 32'(k);
      #1 chk("t4_fill_ready", 32'(req_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t4_dval_idle", 32'(fpu_dval), 32'd0);
    chk("t4_din1_hold", fpu_din1, 32'h103);
    chk("t4_busy_full", 32'(busy), 32'd1);
    // Pop while full must not open a slot in the same cycle.
    fpu_rdy = 1'b1; fpu_result = 32'hAAAA0000;
    #1 chk("t4_no_fwd", 32'(req_ready), 32'd0);
    tick();
    chk("t4_pop0_valid", 32'(rsp_valid), 32'd1);
    chk("t4_pop0_data", rsp_data, 32'hAAAA0000);
    // Push and pop together with three outstanding.
    req_valid = 2'b10; req_a1 = 32'h55555555; req_b1 = 32'h00000001; req_sub = 2'b10;
    fpu_result = 32'hAAAA0001;
    #1 chk("t4_pp_ready", 32'(req_ready), 32'd2);
    tick();
    chk("t4_pop1_valid", 32'(rsp_valid), 32'd1);
    chk("t4_pop1_data", rsp_data, 32'hAAAA0001);
    chk("t4_pp_din1", fpu_din1, 32'h55555555);
    chk("t4_pp_din2", fpu_din2, 32'h80000001);
    req_valid = 2'b01; req_a0 = 32'h777; fpu_rdy = 1'b0;
    #1 chk("t4_refill_ready", 32'(req_ready), 32'd1);
    tick();
    #1 chk("t4_cnt_full", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    exp_tag[0] = 2'b01; exp_tag[1] = 2'b01; exp_tag[2] = 2'b10; exp_tag[3] = 2'b01;
    for (int i = 0; i <= 4; i++) begin
      fpu_rdy    = (i < 4);
      fpu_result = 32'hBBBB0000 + 32'(i);
      if (i >= 1) begin
        chk("t4_drain_tag", 32'(rsp_valid), 32'(exp_tag[i - 1]));
        chk("t4_drain_data", rsp_data, 32'hBBBB0000 + 32'(i - 1));
      end
      tick();
    end
    fpu_rdy = 1'b0;
    chk("t4_busy_end", 32'(busy), 32'd0);
    chk("t4_err_clean", 32'(err), 32'd0);

    // Special values pass through; only the sign of B changes.
    req_valid = 2'b01; req_a0 = 32'h7F800000; req_b0 = 32'hFFC00001; req_sub = 2'b01;
    #1 chk("t5_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    chk("t5_din1_inf", fpu_din1, 32'h7F800000);
    chk("t5_din2_nan", fpu_din2, 32'h7FC00001);
    fpu_rdy = 1'b1; fpu_result = 32'h7FC00000;
    tick();
    fpu_rdy = 1'b0;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t5_rsp_data", rsp_data, 32'h7FC00000);

    // Stray result with nothing outstanding.
    fpu_rdy = 1'b1; fpu_result = 32'hDEAD0000;
    tick();
    fpu_rdy = 1'b0;
    chk("t6_err_set", 32'(err), 32'd1);
    chk("t6_drop_valid", 32'(rsp_valid), 32'd0);
    chk("t6_drop_data", rsp_data, 32'h7FC00000);
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_err_sticky", 32'(err), 32'd1);
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_data", rsp_data, 32'd0);
    chk("t6_rst_din1", fpu_din1, 32'd0);
    chk("t6_rst_din2", fpu_din2, 32'd0);
    chk("t6_rst_dval", 32'(fpu_dval), 32'd0);
    rst = 1'b0; req_valid = 2'b00;
    tick();

    // Reset with three operations in flight.
    req_valid = 2'b01; req_a0 = 32'h1; req_b0 = 32'h2; req_sub = 2'b00;
    tick(); tick(); tick();
    req_valid = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_dval", 32'(fpu_dval), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_no_rsp", 32'(rsp_valid), 32'd0);
    end
    fpu_rdy = 1'b1; fpu_result = 32'h12345678;
    tick();
    fpu_rdy = 1'b0;
    chk("t7_err_after_flush", 32'(err), 32'd1);
    chk("t7_no_rsp_stray", 32'(rsp_valid), 32'd0);
    req_valid = 2'b11;
    #1 chk("t7_prio_reset", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
